// File: rtl/uart_instruction_transmitter.sv
// UART sender for instruction words. A 2-entry FIFO feeds a framer that puts
// a start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits on tx.
module uart_instruction_transmitter #(
  parameter int BAUD_DIVIDER = 434,
  parameter int DATA_BITS    = 15,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] instruction_in,
  input  logic                 instruction_valid,
  output logic                 instruction_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 transmission_done
);

  localparam int BAUD_W = (BAUD_DIVIDER > 0) ? $clog2(BAUD_DIVIDER + 1) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIVIDER);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r, state_next_s;
  logic [DATA_BITS-1:0] fifo_mem_r [2];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [1:0]           count_r;
  logic [1:0]           count_next_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 push_s;
  logic                 pop_s;

  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic [BAUD_W-1:0]    baud_cnt_r, baud_next_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_next_s;
  logic                 stop_cnt_r, stop_next_s;
  logic                 tx_r, tx_next_s;
  logic                 done_r, done_next_s;
  logic                 busy_r;
  logic                 ready_r;

  assign instruction_ready = ready_r;
  assign tx                = tx_r;
  assign busy              = busy_r;
  assign transmission_done = done_r;

  // FIFO push/pop decode and occupancy update
  always_comb begin
    push_s = instruction_valid && ready_r;
    head_s = fifo_mem_r[rd_ptr_r];
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage and pointers; ready tracks the post-update occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem_r[0] <= {DATA_BITS{1'b0}};
      fifo_mem_r[1] <= {DATA_BITS{1'b0}};
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      ready_r       <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= instruction_in;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != 2'd2);
    end
  end

  // Framer next-state and next-output logic
  always_comb begin
    state_next_s = state_r;
    shift_next_s = shift_r;
    baud_next_s  = baud_cnt_r;
    bit_next_s   = bit_cnt_r;
    stop_next_s  = stop_cnt_r;
    tx_next_s    = tx_r;
    done_next_s  = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        tx_next_s = 1'b1;
        if (count_r != 2'd0) begin
          pop_s        = 1'b1;
          shift_next_s = head_s;
          tx_next_s    = 1'b0;
          baud_next_s  = {BAUD_W{1'b0}};
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_next_s  = {BAUD_W{1'b0}};
          tx_next_s    = shift_r[0];
          shift_next_s = shift_r >> 1;
          bit_next_s   = {BIT_W{1'b0}};
          state_next_s = DATA;
        end else begin
          baud_next_s = baud_cnt_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_next_s = {BAUD_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            tx_next_s    = 1'b1;
            stop_next_s  = 1'b0;
            state_next_s = STOP;
          end else begin
            tx_next_s    = shift_r[0];
            shift_next_s = shift_r >> 1;
            bit_next_s   = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          baud_next_s = baud_cnt_r + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_next_s = {BAUD_W{1'b0}};
          if (stop_cnt_r == STOP_LAST) begin
            done_next_s = 1'b1;
            // A queued word starts immediately so frames run back-to-back
            if (count_r != 2'd0) begin
              pop_s        = 1'b1;
              shift_next_s = head_s;
              tx_next_s    = 1'b0;
              state_next_s = START;
            end else begin
              tx_next_s    = 1'b1;
              state_next_s = IDLE;
            end
          end else begin
            stop_next_s = 1'b1;
          end
        end else begin
          baud_next_s = baud_cnt_r + BAUD_W'(1);
        end
      end
      default: begin
        tx_next_s    = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  // Framer state register and registered line outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_BITS{1'b0}};
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      shift_r    <= shift_next_s;
      baud_cnt_r <= baud_next_s;
      bit_cnt_r  <= bit_next_s;
      stop_cnt_r <= stop_next_s;
      tx_r       <= tx_next_s;
      done_r     <= done_next_s;
      busy_r     <= (state_next_s != IDLE);
    end
  end

endmodule

// File: doc/uart_instruction_transmitter.md
Name: uart_instruction_transmitter

Overview:
- Serial sender for 15-bit instructions. It is the transmitting end of the instruction link that uart_instruction_handler receives.
- Accepts instruction words through a valid/ready handshake into a 2-entry FIFO.
- Serializes each word as a UART frame on tx: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
- Used by the bench/host side and by loopback builds to drive instructions into the core.

Parameters:
- BAUD_DIVIDER, 434: bit period is BAUD_DIVIDER+1 clk cycles (counter runs 0..BAUD_DIVIDER).
- DATA_BITS, 15: instruction width and data bits per frame.
- STOP_BITS, 1: number of stop-bit periods (1 or 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- instruction_in  input  DATA_BITS  instruction word to send.
- instruction_valid  input  1  instruction_in valid this cycle.
- instruction_ready  output  1  FIFO can accept; transfer occurs on a clk edge with valid&&ready.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- transmission_done  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (synchronous, active-high, sampled on clk edge):
  - tx=1, busy=0, transmission_done=0, instruction_ready=1.
  - FIFO emptied, counters cleared, state=IDLE.
  - Reset mid-frame abandons the frame: tx is 1 from the reset edge onward and no done pulse is produced.
- FIFO:
  - 2 entries, registered count 0..2; instruction_ready = (count != 2).
  - Push on valid&&ready. Pop when the FSM loads the shift register.
  - Simultaneous push and pop: count unchanged, order preserved.
  - valid while ready=0: ignored, no overwrite.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop head into shift_reg, tx<=0, baud_cnt<=0, go START.
  - START: when baud_cnt==BAUD_DIVIDER: baud_cnt<=0, tx<=shift_reg[0], shift right, bit_cnt<=0, go DATA. Otherwise baud_cnt++.
  - DATA: on baud_cnt==BAUD_DIVIDER:
    - if bit_cnt==DATA_BITS-1: tx<=1, stop_cnt<=0, go STOP;
    - else tx<=shift_reg[0], shift, bit_cnt++.
  - STOP: on baud_cnt==BAUD_DIVIDER:
    - if stop_cnt==STOP_BITS-1: transmission_done<=1 for one cycle, then:
      - FIFO non-empty: pop, tx<=0, go START (back-to-back, zero idle gap);
      - else go IDLE.
    - otherwise stop_cnt++.
- Latency: accept at edge E0; FSM pops at E1; tx low after E1, provided FSM was IDLE.
- Frame length: (1+DATA_BITS+STOP_BITS)*(BAUD_DIVIDER+1) cycles; default 17*435=7395.
- Each tx level is held exactly BAUD_DIVIDER+1 cycles; no glitches; tx is a register output.
- Data order: bit 0 first. No bit reversal and no parity.
- busy = 1 from E1 until the edge returning to IDLE.
- instruction_in changes after acceptance must not affect the frame in flight.
- Widths: baud_cnt is wide enough for BAUD_DIVIDER ($clog2(BAUD_DIVIDER+1)); bit_cnt is $clog2(DATA_BITS).

Test Plan (use BAUD_DIVIDER=3, i.e. 4 clk/bit, for all scenarios):
- Reset, then idle 20 cycles -> tx=1, busy=0, instruction_ready=1, transmission_done=0 throughout.
- Push 15'h5A3C once -> tx low 4 cycles starting after E1, then data bits 0,0,1,1,1,1,0,0,0,1,0,1,1,0,1 at 4 cycles each, then 1 for 4 cycles. A single done pulse occurs 68 cycles after E1. busy falls the same edge.
- Push 15'h7FFF, 15'h0001, 15'h4000 on consecutive cycles -> ready drops after the 3rd push while the 1st is in shift_reg and 2 are queued. Three frames go out back-to-back with no idle gap between them. The receiving model decodes 7FFF, 0001, 4000 in order, with 3 done pulses.
- Hold valid high with ready=0 and a changing word -> the word is not captured. The frame in flight is unchanged.
- Assert reset for 1 cycle in mid-DATA of a frame with a queued word -> tx=1 from that edge, no done pulse. The FIFO is empty and the queued word is never sent.
- Loopback tx into uart_instruction_handler with matching BAUD_DIVIDER. Send 15'h1234 -> instruction_ready pulses and instruction_out==15'h1234.
